lcd_cmd_seq: RTL

LCD_CMD_SEQ -- requirements
Module: lcd_cmd_seq

---
 rtl/lcd_cmd_seq.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/lcd_cmd_seq.sv
`default_nettype none
// ============================================================================
// lcd_cmd_seq - fetches CMD_N commands from a ROM, hands each to the LCD
// controller with a one-cycle strobe, then waits for completion.  Rev 1.0
// ============================================================================
module lcd_cmd_seq #(
  parameter int CMD_N   = 46,
  parameter int TIMEOUT = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       cmd_rom_rd,
  output logic [5:0] cmd_rom_a,
  input  logic [3:0] cmd_rom_q,
  input  logic       busy,
  input  logic       done,
  output logic [3:0] cmd,
  output logic       cmd_valid,
  output logic       seq_busy,
  output logic       seq_done,
  output logic       timeout_err,
  output logic [6:0] issued_cnt
);

  localparam int            TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [5:0]    LAST_A   = 6'(CMD_N - 1);
  localparam logic [6:0]    N_CMDS   = 7'(CMD_N);
  localparam logic [TW-1:0] WAIT_MAX = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_LOAD      = 3'd2,
    S_ISSUE     = 3'd3,
    S_GAP       = 3'd4,
    S_WAIT_DONE = 3'd5,
    S_FINISH    = 3'd6
  } state_t;

  state_t        state_q;
  logic          rd_q;
  logic [5:0]    addr_q;
  logic [3:0]    cmd_q;
  logic          valid_q;
  logic          sbusy_q;
  logic          sdone_q;
  logic          terr_q;
  logic [6:0]    cnt_q;
  logic [TW-1:0] wait_cnt_q;

  // Every output is a register; strobes default low and are raised on the
  // transition into the state in which they must be visible.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      rd_q       <= 1'b0;
      addr_q     <= '0;
      cmd_q      <= '0;
      valid_q    <= 1'b0;
      sbusy_q    <= 1'b0;
      sdone_q    <= 1'b0;
      terr_q     <= 1'b0;
      cnt_q      <= '0;
      wait_cnt_q <= '0;
    end else begin
      rd_q    <= 1'b0;
      valid_q <= 1'b0;
      sdone_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_FETCH;
            rd_q    <= 1'b1;
            sbusy_q <= 1'b1;
            addr_q  <= '0;
            cnt_q   <= '0;
            terr_q  <= 1'b0;
          end
        end
        S_FETCH: state_q <= S_LOAD;
        S_LOAD: begin
          cmd_q   <= cmd_rom_q;
          state_q <= S_ISSUE;
        end
        S_ISSUE: begin
          if (!busy) begin
            valid_q <= 1'b1;
            cnt_q   <= cnt_q + 7'd1;
            if (addr_q != LAST_A) begin
              addr_q <= addr_q + 6'd1;
            end
            state_q <= S_GAP;
          end
        end
        // busy is not looked at here: the controller needs a cycle to raise it
        S_GAP: begin
          if (cnt_q == N_CMDS) begin
            state_q    <= S_WAIT_DONE;
            wait_cnt_q <= '0;
          end else begin
            state_q <= S_FETCH;
            rd_q    <= 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (done) begin
            state_q <= S_FINISH;
            sdone_q <= 1'b1;
          end else if (wait_cnt_q == WAIT_MAX) begin
            state_q <= S_IDLE;
            sbusy_q <= 1'b0;
            terr_q  <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + TW'(1);
          end
        end
        S_FINISH: begin
          state_q <= S_IDLE;
          sbusy_q <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          sbusy_q <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_rom_rd  = rd_q;
  assign cmd_rom_a   = addr_q;
  assign cmd         = cmd_q;
  assign cmd_valid   = valid_q;
  assign seq_busy    = sbusy_q;
  assign seq_done    = sdone_q;
  assign timeout_err = terr_q;
  assign issued_cnt  = cnt_q;

endmodule
`default_nettype wire
